// File: rtl/fft_frame_sequencer_if.sv
// fft_frame_sequencer_if: FFT config and frame-sample AXI-stream channels.
interface fft_frame_sequencer_if;
  logic [15:0] cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready;
  logic [31:0] frame_tdata;
  logic        frame_tvalid;
  logic        frame_tready;
  logic        frame_tlast;
  modport master (
    output cfg_tdata, cfg_tvalid, frame_tdata, frame_tvalid, frame_tlast,
    input  cfg_tready, frame_tready
  );
  modport slave (
    input  cfg_tdata, cfg_tvalid, frame_tdata, frame_tvalid, frame_tlast,
    output cfg_tready, frame_tready
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: configures the FFT core when the scaling changes, then streams one BRAM frame oldest-first.
// Define AUTO_TRIGGER_EN to add a free-running trigger every TRIG_PERIOD cycles.
module fft_frame_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int FRAME_LEN   = 4096,
  parameter int SAMPLE_W    = 16,
  parameter int TRIG_PERIOD = 1048576
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                start,
  input  logic [ADDR_W-1:0]   head,
  input  logic [11:0]         scale_sch,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [SAMPLE_W-1:0] rd_data,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         overrun_cnt,
  fft_frame_sequencer_if.master axis
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  if (FRAME_LEN > 2**ADDR_W || SAMPLE_W > 16 || TRIG_PERIOD < 1) begin : g_bad_params
    $error("fft_frame_sequencer: illegal parameter combination");
  end
  typedef enum logic [1:0] {IDLE, CFG, STREAM} state_t;
  state_t r_state, w_next;
  logic              w_trig;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_left;
  logic [11:0]       r_scale_q, r_scale_sent;
  logic              r_cfg_dirty, r_done, r_pend, r_pend_last;
  logic [15:0]       r_ovr;
  logic [15:0]       r_buf_d [2];
  logic              r_buf_l [2];
  logic              r_rp, r_wp;
  logic [1:0]        r_cnt, w_after;
  logic [15:0]       w_ext, w_odata;
  logic              w_dirty, w_cfg_hs, w_valid, w_olast, w_pop, w_push, w_bpop, w_issue, w_last_hs;
`ifdef AUTO_TRIGGER_EN
  localparam int TC_W = TRIG_PERIOD > 1 ? $clog2(TRIG_PERIOD) : 1;
  logic [TC_W-1:0] r_tcnt;
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) r_tcnt <= '0;
    else r_tcnt <= (r_tcnt == TC_W'(TRIG_PERIOD - 1)) ? '0 : r_tcnt + 1'b1;
  assign w_trig = start | (r_tcnt == TC_W'(TRIG_PERIOD - 1));
`else
  assign w_trig = start;
`endif
  // Output comes straight from BRAM when the skid buffer is empty, so the first sample meets the 2-cycle latency.
  assign w_ext     = 16'($signed(rd_data));
  assign w_valid   = (r_cnt != 2'd0) | r_pend;
  assign w_odata   = (r_cnt != 2'd0) ? r_buf_d[r_rp] : w_ext;
  assign w_olast   = (r_cnt != 2'd0) ? r_buf_l[r_rp] : r_pend_last;
  assign w_pop     = w_valid & axis.frame_tready;
  assign w_push    = r_pend & ~((r_cnt == 2'd0) & w_pop);
  assign w_bpop    = w_pop & (r_cnt != 2'd0);
  assign w_after   = r_cnt + 2'(r_pend) - 2'(w_pop);
  assign w_issue   = (r_state == STREAM) & (r_left != '0) & (w_after <= 2'd1);
  assign w_last_hs = w_pop & w_olast;
  assign w_dirty   = r_cfg_dirty | (scale_sch != r_scale_sent);
  assign w_cfg_hs  = (r_state == CFG) & axis.cfg_tready;
  assign rd_addr           = r_addr;
  assign busy              = r_state != IDLE;
  assign frame_done        = r_done;
  assign overrun_cnt       = r_ovr;
  assign axis.cfg_tvalid   = r_state == CFG;
  assign axis.cfg_tdata    = (r_state == CFG) ? {3'b0, r_scale_q, 1'b1} : '0;
  assign axis.frame_tvalid = w_valid;
  assign axis.frame_tdata  = w_valid ? {16'b0, w_odata} : '0;
  assign axis.frame_tlast  = w_valid & w_olast;
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && w_trig) ? (w_dirty ? CFG : STREAM) :
             w_cfg_hs ? STREAM : w_last_hs ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      r_addr       <= '0;
      r_left       <= '0;
      r_scale_q    <= '0;
      r_scale_sent <= '0;
      r_cfg_dirty  <= 1'b1;
      r_done       <= 1'b0;
      r_ovr        <= '0;
      r_pend       <= 1'b0;
      r_pend_last  <= 1'b0;
      r_buf_d      <= '{default: '0};
      r_buf_l      <= '{default: 1'b0};
      r_rp         <= 1'b0;
      r_wp         <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_done <= w_last_hs;
      if (w_trig && r_state != IDLE && r_ovr != 16'hFFFF) r_ovr <= r_ovr + 1'b1;
      if (r_state == IDLE && w_trig) begin
        r_addr      <= head - ADDR_W'(FRAME_LEN);
        r_left      <= CNT_W'(FRAME_LEN);
        r_scale_q   <= scale_sch;
        r_cfg_dirty <= w_dirty;
      end
      if (w_cfg_hs) begin
        r_scale_sent <= r_scale_q;
        r_cfg_dirty  <= 1'b0;
      end
      if (w_issue) begin
        r_addr <= r_addr + 1'b1;
        r_left <= r_left - 1'b1;
      end
      r_pend      <= w_issue;
      r_pend_last <= w_issue & (r_left == CNT_W'(1));
      if (w_push) begin
        r_buf_d[r_wp] <= w_ext;
        r_buf_l[r_wp] <= r_pend_last;
        r_wp          <= ~r_wp;
      end
      if (w_bpop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_bpop);
    end
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Controller that sequences the mic FFT datapath. Each trigger, it first configures the FFT core over its AXI-stream config channel when needed.
- It then reads one frame of PCM samples from the circular frame BRAM, oldest sample first, and streams them to the FFT AXI-stream input with tlast on the final sample.
- Sits between the frame BRAM read port and the FFT wrapper; one instance per mic core.

Parameters:
- ADDR_W, 12, frame BRAM address width.
- FRAME_LEN, 4096, samples per frame; must be ≤ 2^ADDR_W.
- SAMPLE_W, 16, PCM sample width; must be ≤ 16.
- TRIG_PERIOD, 1048576, auto-trigger period in clk cycles; used only with AUTO_TRIGGER_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame trigger request.
- head  in  ADDR_W  BRAM write pointer: next location to be written.
- scale_sch  in  12  FFT scaling schedule.
- rd_addr  out  ADDR_W  BRAM read address.
- rd_data  in  SAMPLE_W  BRAM read data, valid 1 cycle after rd_addr.
- cfg_tdata  out  16  FFT config word.
- cfg_tvalid  out  1  config valid.
- cfg_tready  in  1  config ready.
- frame_tdata  out  32  FFT input sample.
- frame_tvalid  out  1  sample valid.
- frame_tready  in  1  FFT ready.
- frame_tlast  out  1  last sample of frame.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse after the final handshake.
- overrun_cnt  out  16  saturating count of dropped triggers.

Behaviour:
- Reset values: all outputs 0; cfg_dirty = 1; state = IDLE.
- Trigger = start, or the internal auto-trigger when AUTO_TRIGGER_EN is compiled in.
- Trigger in IDLE:
  - Capture base = (head − FRAME_LEN) mod 2^ADDR_W.
  - Capture scale_sch into scale_q.
  - Set cfg_dirty if scale_q differs from the last value sent.
  - Next state is CFG if cfg_dirty, else STREAM.
- Trigger while busy: ignored; overrun_cnt += 1, saturating at 0xFFFF.
- CFG state:
  - cfg_tdata = {3'b0, scale_q, 1'b1}, where bit0 = forward.
  - cfg_tvalid is held with cfg_tdata stable until cfg_tready.
  - On handshake: record scale_q as last sent, clear cfg_dirty, go to STREAM.
- STREAM state:
  - Issue FRAME_LEN reads, rd_addr = base, base+1, … mod 2^ADDR_W (wraps at the 2^ADDR_W−1 → 0 boundary).
  - frame_tdata = {16'b0, sign-extended rd_data to 16}: imaginary part 0.
  - frame_tlast = 1 only on sample index FRAME_LEN−1.
  - AXI rules:
    - Once frame_tvalid rises, frame_tvalid, frame_tdata and frame_tlast hold until frame_tready.
    - No sample is dropped, duplicated or reordered under any frame_tready pattern.
  - Implementation: 2-entry skid buffer covering the 1-cycle BRAM latency; a read is issued only when a slot is guaranteed.
- Latency, no config, frame_tready = 1:
  - Trigger at cycle T.
  - rd_addr = base at T+1.
  - First frame_tvalid at T+2.
  - Full throughput of 1 sample/cycle; last handshake at T+1+FRAME_LEN.
- After the tlast handshake:
  - Next cycle: frame_done = 1, state = IDLE.
  - A trigger in that same cycle is accepted, with no overrun.
- head changing during a frame has no effect; base is captured at the trigger.
- Reset mid-frame: outputs drop to 0 immediately (asynchronous), and cfg_dirty = 1 so the next frame reconfigures the FFT.

Optional Feature:
- Macro: AUTO_TRIGGER_EN.
- Defined:
  - A free-running counter pulses an internal trigger every TRIG_PERIOD cycles, OR'd with start.
  - The first pulse comes TRIG_PERIOD cycles after reset.
  - Dropped auto-triggers count in overrun_cnt.
- Undefined: counter absent; only start triggers.

Test Plan:
All scenarios use FRAME_LEN=16 and ADDR_W=6, with the BRAM model holding value = address.
- Reset release, scale_sch=0x2AB, start, head=20, cfg_tready=1, frame_tready=1 -> expected response:
  - cfg_tdata=0x0557, one handshake.
  - Then samples 4..19; tlast only on 19.
  - frame_done one cycle after the tlast handshake.
- Second start, same scale_sch, head=8 -> expected response:
  - No cfg_tvalid.
  - Addresses 56..63 then 0..7 (wrap).
  - First tvalid exactly 2 cycles after start.
- Random frame_tready (50%) over 3 frames -> expected response:
  - Exactly 16 handshakes per frame, in order.
  - tvalid/tdata/tlast never change while tvalid=1 and tready=0.
- start pulsed 3 times mid-frame, then 70000 times -> expected response:
  - overrun_cnt=3, then saturates at 0xFFFF.
  - The current frame completes unchanged.
- aresetn low at sample 7, then start with scale_sch unchanged -> expected response:
  - All outputs 0 during reset.
  - The next frame re-sends the config word before data.
- AUTO_TRIGGER_EN, TRIG_PERIOD=40, start tied 0 -> expected response:
  - Frames begin 40 cycles after reset and every 40 cycles thereafter.
  - overrun_cnt stays 0.
